// File: rtl/reg_file_2r.sv
// -----------------------------------------------------------------------------
// reg_file_2r
//
// Storage array with one synchronous write port and two independent
// synchronous read ports (A and B). Each entry carries a valid bit; an entry
// that is not valid reads as all zeros. Writes are merged through a per-bit
// mask against the entry's effective old word. The valid map is cleared by
// clr, and n_valid tracks how many entries are currently valid.
//
// Parameters
//   B       data width in bits
//   W       address width; depth = 2**W
//   BYPASS  1: a read and a write to the same address on the same edge
//              return the newly merged word
//           0: the read returns the effective old word
//
// Ports
//   clk                  rising-edge clock
//   reset                synchronous, active-high reset (highest priority)
//   clr                  synchronous clear of every entry valid bit
//   wr_en/w_addr/w_data  write strobe, address, data
//   w_mask               per-bit write enable (1 = bit updated)
//   re_x/r_addr_x        port x read strobe and address (x = a, b)
//   r_data_x             port x registered read data
//   r_ack_x              port x registered read acknowledge
//   r_hit_x              port x: the entry read was valid
//   n_valid              number of valid entries, 0..2**W
// -----------------------------------------------------------------------------
module reg_file_2r #(
    parameter int B      = 8,
    parameter int W      = 2,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [W-1:0] w_addr,
    input  logic [B-1:0] w_data,
    input  logic [B-1:0] w_mask,
    input  logic         re_a,
    input  logic [W-1:0] r_addr_a,
    output logic [B-1:0] r_data_a,
    output logic         r_ack_a,
    output logic         r_hit_a,
    input  logic         re_b,
    input  logic [W-1:0] r_addr_b,
    output logic [B-1:0] r_data_b,
    output logic         r_ack_b,
    output logic         r_hit_b,
    output logic [W:0]   n_valid
);

    localparam int DEPTH     = 1 << W;
    localparam bit BYPASS_EN = (BYPASS != 0);

    // Storage and valid map
    logic [B-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [W:0]       n_valid_q;
    logic [W:0]       n_valid_d;

    // Registered read outputs
    logic [B-1:0] r_data_a_q, r_data_b_q;
    logic [B-1:0] r_data_a_d, r_data_b_d;
    logic         r_hit_a_q,  r_hit_b_q;
    logic         r_hit_a_d,  r_hit_b_d;
    logic         r_ack_a_q,  r_ack_b_q;

    // Write merge. A clear on the same edge makes the old word zero, so the
    // written entry starts from a clean slate.
    logic [B-1:0] w_old;
    logic [B-1:0] w_merged;

    assign w_old    = (clr || !valid_q[w_addr]) ? '0 : mem_q[w_addr];
    assign w_merged = (w_old & ~w_mask) | (w_data & w_mask);

    // Read paths. Reads see the pre-clear valid map; bypass forwards the
    // merged word so the reader sees exactly what is being stored.
    logic bypass_a, bypass_b;

    assign bypass_a = BYPASS_EN && wr_en && (r_addr_a == w_addr);
    assign bypass_b = BYPASS_EN && wr_en && (r_addr_b == w_addr);

    assign r_data_a_d = bypass_a ? w_merged
                      : (valid_q[r_addr_a] ? mem_q[r_addr_a] : '0);
    assign r_hit_a_d  = bypass_a | valid_q[r_addr_a];
    assign r_data_b_d = bypass_b ? w_merged
                      : (valid_q[r_addr_b] ? mem_q[r_addr_b] : '0);
    assign r_hit_b_d  = bypass_b | valid_q[r_addr_b];

    // Next valid map and its population count
    // NOTE: every variable driven in always_comb gets a default assignment
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = clr ? '0 : valid_q;
        if (wr_en) begin
            valid_d[w_addr] = 1'b1;
        end
    end

    always_comb begin
        n_valid_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_valid_d = n_valid_d + {{W{1'b0}}, valid_d[i]};
        end
    end

    // Control state and read outputs
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            n_valid_q  <= '0;
            r_data_a_q <= '0;
            r_hit_a_q  <= 1'b0;
            r_ack_a_q  <= 1'b0;
            r_data_b_q <= '0;
            r_hit_b_q  <= 1'b0;
            r_ack_b_q  <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            n_valid_q <= n_valid_d;
            r_ack_a_q <= re_a;
            r_ack_b_q <= re_b;
            if (re_a) begin
                r_data_a_q <= r_data_a_d;
                r_hit_a_q  <= r_hit_a_d;
            end
            if (re_b) begin
                r_data_b_q <= r_data_b_d;
                r_hit_b_q  <= r_hit_b_d;
            end
        end
    end

    // Array contents
    // NOTE: the array itself is deliberately not reset; the valid map masks
    // stale contents, which keeps the storage a plain RAM-style structure.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[w_addr] <= w_merged;
        end
    end

    assign r_data_a = r_data_a_q;
    assign r_hit_a  = r_hit_a_q;
    assign r_ack_a  = r_ack_a_q;
    assign r_data_b = r_data_b_q;
    assign r_hit_b  = r_hit_b_q;
    assign r_ack_b  = r_ack_b_q;
    assign n_valid  = n_valid_q;

endmodule

// File: tb/tb_reg_file_2r.sv
// -----------------------------------------------------------------------------
// tb_reg_file_2r
//
// Directed bench for reg_file_2r. Two instances share every input: u_byp
// (BYPASS=1) and u_nob (BYPASS=0). They differ only when a read and a write
// hit the same address on the same edge. Inputs change 1 ns after a rising
// edge and outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_reg_file_2r;

    localparam int B = 8;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         clr;
    logic         wr_en;
    logic [W-1:0] w_addr;
    logic [B-1:0] w_data;
    logic [B-1:0] w_mask;
    logic         re_a;
    logic [W-1:0] r_addr_a;
    logic         re_b;
    logic [W-1:0] r_addr_b;

    logic [B-1:0] y_data_a, y_data_b, n_data_a, n_data_b;
    logic         y_ack_a,  y_ack_b,  n_ack_a,  n_ack_b;
    logic         y_hit_a,  y_hit_b,  n_hit_a,  n_hit_b;
    logic [W:0]   y_n_valid, n_n_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_2r #(.B(B), .W(W), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .clr(clr),
        .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
        .re_a(re_a), .r_addr_a(r_addr_a),
        .r_data_a(y_data_a), .r_ack_a(y_ack_a), .r_hit_a(y_hit_a),
        .re_b(re_b), .r_addr_b(r_addr_b),
        .r_data_b(y_data_b), .r_ack_b(y_ack_b), .r_hit_b(y_hit_b),
        .n_valid(y_n_valid)
    );

    reg_file_2r #(.B(B), .W(W), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .clr(clr),
        .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
        .re_a(re_a), .r_addr_a(r_addr_a),
        .r_data_a(n_data_a), .r_ack_a(n_ack_a), .r_hit_a(n_hit_a),
        .re_b(re_b), .r_addr_b(r_addr_b),
        .r_data_b(n_data_b), .r_ack_b(n_ack_b), .r_hit_b(n_hit_b),
        .n_valid(n_n_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; clr = 1'b0; wr_en = 1'b0; re_a = 1'b0; re_b = 1'b0;
    endtask

    task automatic wr(input logic [W-1:0] a, input logic [B-1:0] d,
                      input logic [B-1:0] m);
        wr_en = 1'b1; w_addr = a; w_data = d; w_mask = m;
    endtask

    task automatic rd_a(input logic [W-1:0] a);
        re_a = 1'b1; r_addr_a = a;
    endtask

    task automatic rd_b(input logic [W-1:0] a);
        re_b = 1'b1; r_addr_b = a;
    endtask

    initial begin
        idle();
        w_addr = '0; w_data = '0; w_mask = '0; r_addr_a = '0; r_addr_b = '0;

        // Reset
        reset = 1'b1;
        step();
        step();
        check("rst_ack_a",   y_ack_a,   0);
        check("rst_ack_b",   y_ack_b,   0);
        check("rst_data_a",  y_data_a,  0);
        check("rst_hit_a",   y_hit_a,   0);
        check("rst_n_valid", y_n_valid, 0);
        check("rst_n_valid_nob", n_n_valid, 0);

        // Read every address while empty
        for (int i = 0; i < 4; i++) begin
            idle(); rd_a(i[W-1:0]);
            step();
            check($sformatf("empty_ack_a%0d",  i), y_ack_a,  1);
            check($sformatf("empty_data_a%0d", i), y_data_a, 8'h00);
            check($sformatf("empty_hit_a%0d",  i), y_hit_a,  0);
            check($sformatf("empty_nv%0d",     i), y_n_valid, 0);
        end

        // Full write to addr1, then dual read
        idle(); wr(2'd1, 8'hA5, 8'hFF);
        step();
        check("wr1_n_valid", y_n_valid, 1);
        check("wr1_no_ack",  y_ack_a,   0);
        idle(); rd_a(2'd1); rd_b(2'd1);
        step();
        check("rd1_data_a", y_data_a, 8'hA5);
        check("rd1_hit_a",  y_hit_a,  1);
        check("rd1_ack_a",  y_ack_a,  1);
        check("rd1_data_b", y_data_b, 8'hA5);
        check("rd1_hit_b",  y_hit_b,  1);
        check("rd1_ack_b",  y_ack_b,  1);

        // Masked write to valid addr1: (A5 & F0) | (3C & 0F) = AC
        idle(); wr(2'd1, 8'h3C, 8'h0F);
        step();
        idle(); rd_a(2'd1);
        step();
        check("mask1_data", y_data_a,  8'hAC);
        check("mask1_nv",   y_n_valid, 1);

        // Masked write to invalid addr2: unmasked bits zero-fill -> F0
        idle(); wr(2'd2, 8'hFF, 8'hF0);
        step();
        check("mask2_nv", y_n_valid, 2);
        idle(); rd_b(2'd2);
        step();
        check("mask2_data_b", y_data_b, 8'hF0);
        check("mask2_hit_b",  y_hit_b,  1);

        // No strobe: ack drops, data and hit hold
        idle();
        step();
        check("hold_ack_b",  y_ack_b,  0);
        check("hold_data_b", y_data_b, 8'hF0);
        check("hold_hit_b",  y_hit_b,  1);

        // Read-during-write to addr3
        idle(); wr(2'd3, 8'h77, 8'hFF); rd_a(2'd3);
        step();
        check("byp_data_a",  y_data_a,  8'h77);
        check("byp_hit_a",   y_hit_a,   1);
        check("nob_data_a",  n_data_a,  8'h00);
        check("nob_hit_a",   n_hit_a,   0);
        check("rdw_nv",      y_n_valid, 3);
        check("rdw_nv_nob",  n_n_valid, 3);
        idle(); rd_a(2'd3);
        step();
        check("nob_after_data", n_data_a, 8'h77);
        check("nob_after_hit",  n_hit_a,  1);

        // Different addresses: zero-mask rewrite of addr2 while reading addr1
        idle(); wr(2'd2, 8'h00, 8'h00); rd_a(2'd1);
        step();
        check("diff_data_byp", y_data_a,  8'hAC);
        check("diff_data_nob", n_data_a,  8'hAC);
        check("diff_nv",       y_n_valid, 3);
        idle(); rd_a(2'd2);
        step();
        check("mask0_keeps", y_data_a, 8'hF0);

        // Clear with a simultaneous write to addr0 and reads on both ports
        idle(); clr = 1'b1; wr(2'd0, 8'h11, 8'hFF); rd_a(2'd0); rd_b(2'd2);
        step();
        check("clr_nv",          y_n_valid, 1);
        check("clr_nv_nob",      n_n_valid, 1);
        check("clr_rdb_data",    y_data_b,  8'hF0);
        check("clr_rdb_hit",     y_hit_b,   1);
        check("clr_byp_data_a",  y_data_a,  8'h11);
        check("clr_byp_hit_a",   y_hit_a,   1);
        check("clr_nob_data_a",  n_data_a,  8'h00);
        check("clr_nob_hit_a",   n_hit_a,   0);
        for (int i = 1; i < 4; i++) begin
            idle(); rd_a(i[W-1:0]);
            step();
            check($sformatf("clr_data%0d", i), y_data_a, 8'h00);
            check($sformatf("clr_hit%0d",  i), y_hit_a,  0);
        end
        idle(); rd_a(2'd0); rd_b(2'd0);
        step();
        check("clr_a0_data", y_data_a, 8'h11);
        check("clr_a0_hit",  y_hit_a,  1);
        check("clr_b0_data", y_data_b, 8'h11);

        // Fill all entries, then rewrite addr0: count saturates at 4
        idle(); wr(2'd1, 8'h01, 8'hFF); step();
        check("fill_nv2", y_n_valid, 2);
        idle(); wr(2'd2, 8'h02, 8'hFF); step();
        check("fill_nv3", y_n_valid, 3);
        idle(); wr(2'd3, 8'h03, 8'hFF); step();
        check("fill_nv4", y_n_valid, 4);
        // (11 & F0) | (55 & 0F) = 15
        idle(); wr(2'd0, 8'h55, 8'h0F); step();
        check("full_rewrite_nv", y_n_valid, 4);
        idle(); rd_a(2'd0); rd_b(2'd3);
        step();
        check("full_a0_data", y_data_a, 8'h15);
        check("full_b3_data", y_data_b, 8'h03);

        // Reset alongside a read and a write: both discarded
        idle(); reset = 1'b1; rd_a(2'd0); wr(2'd1, 8'hEE, 8'hFF);
        step();
        check("midrst_ack_a",  y_ack_a,   0);
        check("midrst_data_a", y_data_a,  8'h00);
        check("midrst_hit_a",  y_hit_a,   0);
        check("midrst_nv",     y_n_valid, 0);
        idle(); rd_a(2'd0); rd_b(2'd1);
        step();
        check("post_rst_ack_a",  y_ack_a,   1);
        check("post_rst_hit_a",  y_hit_a,   0);
        check("post_rst_data_a", y_data_a,  8'h00);
        check("post_rst_hit_b",  y_hit_b,   0);
        check("post_rst_data_b", y_data_b,  8'h00);
        check("post_rst_nv",     y_n_valid, 0);

        idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
